icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
// - Direct-mapped, read-only instruction cache between the fetch stage (IFU) and the burst-to-single AXI4 fetch master.
// - Hits answer in 1 cycle. Misses issue one line-refill burst request (len = LINE_WORDS-1) and install the returned beats.
// - The cache returns the requested word as soon as the refill completes.
// - A fence.i-style flush invalidates every line.
// PARAMETERS
// - LINE_WORDS  4   32-bit words per line; power of 2, >=2
// - NUM_SETS    16  number of lines; power of 2
// - Derived: OFF_W = log2(LINE_WORDS)+2, IDX_W = log2(NUM_SETS), TAG_W = 32-IDX_W-OFF_W
// PORTS
// - clk             in   1      clock, all flops on posedge
// - rst_n           in   1      reset; asynchronous assert, active-low
// - ifu_req_valid   in   1      fetch request
// - ifu_req_addr    in   32     fetch byte address; bits [1:0] ignored
// - ifu_req_ready   out  1      request accepted when valid&ready
// - ifu_kill        in   1      pipeline redirect: drop the pending response
// - ifu_resp_valid  out  1      1-cycle pulse, response data valid
// - ifu_resp_data   out  32     instruction word
// - flush           in   1      invalidate all lines, cancel the pending fetch
// - mem_req         out  1      1-cycle refill request pulse
// - mem_addr        out  32     line-aligned refill address
// - mem_len         out  8      constant LINE_WORDS-1
// - mem_flush       out  1      tied 0; the cache handles cancellation itself
// - mem_rvalid      in   1      refill beat valid (1-cycle pulse)
// - mem_rdata       in   32     refill beat data
// - mem_rlast       in   1      last beat; downstream is idle in the same cycle
// BEHAVIOUR
// Reset (rst_n=0)
// - state=IDLE; all valid bits, beat_cnt, cancel and kill flags = 0.
// - ifu_req_ready=1 after release; ifu_resp_valid=0; ifu_resp_data=0; mem_req=0; mem_addr=0.
// Address fields
// - offset = addr[OFF_W-1:2]; index = addr[OFF_W+IDX_W-1:OFF_W]; tag = addr[31:OFF_W+IDX_W].
// Handshake
// - ifu_req_ready = (state==IDLE) & !flush.
// - At most one request is outstanding; ifu_resp_valid is never held for more than 1 cycle.
// States
// - IDLE
//   - Accept on valid&ready; lookup is combinational.
//   - Hit: latch data, go to RESP.
//   - Miss: latch addr, go to MREQ.
// - MREQ
//   - mem_req=1 for exactly 1 cycle; mem_addr = {tag,index,0}; beat_cnt=0.
//   - Next state: MWAIT.
// - MWAIT
//   - Each mem_rvalid: write mem_rdata to data[index][beat_cnt]; beat_cnt++ (wraps mod LINE_WORDS).
//   - If beat_cnt==offset, capture the word as the critical word.
//   - On mem_rlast: set valid and tag unless cancel=1; go to RESP.
// - RESP
//   - ifu_resp_valid=1 with the latched word unless cancel or kill; clear both flags; go to IDLE.
// Cancellation
// - flush in IDLE: all valid bits cleared that cycle; no request accepted.
// - flush in MREQ/MWAIT: clear valid bits; set cancel.
//   - Beats still drain until mem_rlast. The line is not validated and there is no response.
//   - mem_req is never reissued for that fetch.
// - flush in RESP: response suppressed.
// - ifu_kill in RESP or MREQ/MWAIT: response suppressed only; the refill still installs the line.
// - ifu_kill in the same cycle as acceptance: the request is still accepted, but its response is suppressed.
// Simultaneous events
// - flush and mem_rlast in the same cycle: cancel wins; the line stays invalid.
// - ifu_kill and flush: both take effect.
// - mem_rvalid outside MWAIT: ignored.
// - rlast is authoritative; beats beyond LINE_WORDS overwrite via the wrap.
// Miscellaneous
// - Latency: hit = 1 cycle accept->resp; miss = refill time + 1.
// - Under `SIMULATION: 64-bit hit and miss counters, reset to 0.
// STRUCTURE
// - icache_defs.vh: state encodings (IDLE/MREQ/MWAIT/RESP), OFF_W/IDX_W/TAG_W localparam formulas.
// - Sub-module icache_data_array: NUM_SETS x LINE_WORDS x 32 flop array; 1 sync write port, 1 combinational read port.
// - Tag and valid arrays stay in the top.
// TESTING (LINE_WORDS=4, NUM_SETS=16: index=addr[7:4], tag=addr[31:8])
// 1. Cold fetch 0x3000_0004
//    - mem_req pulse, addr 0x3000_0000, len 3.
//    - Beats 0x11,0x22,0x33,0x44(last) -> resp 0x22 one cycle after rlast.
//    - Then fetch 0x3000_000C -> resp 0x44 next cycle, no mem_req.
// 2. Conflict: after test 1, fetch 0x3000_0104
//    - miss, refill at 0x3000_0100.
//    - Re-fetch 0x3000_0004 -> misses again.
// 3. flush after beat 2 of a refill
//    - Remaining beats drained; no resp_valid.
//    - Re-fetch of the same address -> new mem_req.
// 4. ifu_kill during refill
//    - No resp; the following fetch of the same line hits with 0 mem_req.
// 5. flush plus ifu_req_valid in IDLE
//    - ready=0, request not accepted.
//    - All lines invalid; the next fetch of a previously cached address misses.
// 6. rst_n low mid-MWAIT
//    - All outputs at reset values immediately; ready=1 after release.
//    - The earlier line misses.

Source files
------------

// File: rtl/icache_dm_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_dm_pkg;

    localparam int ADDR_W         = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_SETS   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Byte-offset width of a line: word-select bits plus the two byte bits.
    function automatic int offW(input int lineWords);
        return $clog2(lineWords) + 2;
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// master = fetch stage plus memory responder, slave = the cache itself.
interface icache_dm_if;
    import icache_dm_pkg::*;

    logic              ifu_req_valid;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_req_ready;
    logic              ifu_kill;
    logic              ifu_resp_valid;
    logic [31:0]       ifu_resp_data;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_len;
    logic              mem_flush;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              mem_rlast;

    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_kill, flush,
               mem_rvalid, mem_rdata, mem_rlast,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
               mem_req, mem_addr, mem_len, mem_flush
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_kill, flush,
               mem_rvalid, mem_rdata, mem_rlast,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
               mem_req, mem_addr, mem_len, mem_flush
    );

endinterface

// File: rtl/icache_dm_data_array.sv
// Line storage: NUM_SETS x LINE_WORDS words, one synchronous write port and
// one combinational read port.
module icache_dm_data_array #(
    parameter  int LINE_WORDS = 4,
    parameter  int NUM_SETS   = 16,
    localparam int WORD_W     = $clog2(LINE_WORDS),
    localparam int IDX_W      = $clog2(NUM_SETS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wIdx_i,
    input  logic [WORD_W-1:0] wOff_i,
    input  logic [31:0]       wData_i,
    input  logic [IDX_W-1:0]  rIdx_i,
    input  logic [WORD_W-1:0] rOff_i,
    output logic [31:0]       rData_o
);

    logic [31:0] mem_q [NUM_SETS][LINE_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wIdx_i][wOff_i] <= wData_i;
        end
    end

    assign rData_o = mem_q[rIdx_i][rOff_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: one-cycle hits, single-burst
// line refill on a miss, whole-cache invalidation on flush.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_SETS   = DEF_NUM_SETS
) (
    input logic        clk,
    input logic        rst_n,
    icache_dm_if.slave bus
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = offW(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   beatCnt_q, beatCnt_d;
    logic                cancel_q, cancel_d;
    logic                kill_q, kill_d;
    logic [31:0]         word_q, word_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [NUM_SETS];

    logic [IDX_W-1:0]  reqIdx, fillIdx;
    logic [WORD_W-1:0] reqOff, fillOff;
    logic [TAG_W-1:0]  reqTag, fillTag;
    logic [31:0]       rdWord;
    logic              hit, ready, accept, arrWe, tagWe;
    logic              unusedByteBits;

    assign reqOff  = bus.ifu_req_addr[OFF_W-1:2];
    assign reqIdx  = bus.ifu_req_addr[OFF_W+IDX_W-1:OFF_W];
    assign reqTag  = bus.ifu_req_addr[ADDR_W-1:OFF_W+IDX_W];
    assign fillOff = addr_q[OFF_W-1:2];
    assign fillIdx = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign fillTag = addr_q[ADDR_W-1:OFF_W+IDX_W];
    assign unusedByteBits = ^{bus.ifu_req_addr[1:0], addr_q[1:0]};

    assign hit    = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag);
    assign ready  = (state_q == IDLE) && !bus.flush;
    assign accept = bus.ifu_req_valid && ready;

    icache_dm_data_array #(
        .LINE_WORDS(LINE_WORDS),
        .NUM_SETS  (NUM_SETS)
    ) u_data (
        .clk    (clk),
        .we_i   (arrWe),
        .wIdx_i (fillIdx),
        .wOff_i (beatCnt_q),
        .wData_i(bus.mem_rdata),
        .rIdx_i (reqIdx),
        .rOff_i (reqOff),
        .rData_o(rdWord)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beatCnt_d = beatCnt_q;
        cancel_d  = cancel_q;
        kill_d    = kill_q;
        word_d    = word_q;
        valid_d   = valid_q;
        arrWe     = 1'b0;
        tagWe     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = bus.ifu_req_addr;
                    kill_d = bus.ifu_kill;
                    if (hit) begin
                        word_d  = rdWord;
                        state_d = RESP;
                    end else begin
                        state_d = MREQ;
                    end
                end
            end
            MREQ: begin
                beatCnt_d = '0;
                kill_d    = kill_q | bus.ifu_kill;
                state_d   = MWAIT;
            end
            MWAIT: begin
                kill_d = kill_q | bus.ifu_kill;
                if (bus.mem_rvalid) begin
                    arrWe     = 1'b1;
                    beatCnt_d = beatCnt_q + 1'b1;
                    if (beatCnt_q == fillOff) begin
                        word_d = bus.mem_rdata;
                    end
                    // A flush arriving with the last beat still keeps the line invalid.
                    if (bus.mem_rlast) begin
                        tagWe   = !cancel_q && !bus.flush;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                cancel_d = 1'b0;
                kill_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            valid_d = '0;
            if (state_q == MREQ || state_q == MWAIT) begin
                cancel_d = 1'b1;
            end
        end
        if (tagWe) begin
            valid_d[fillIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            beatCnt_q <= '0;
            cancel_q  <= 1'b0;
            kill_q    <= 1'b0;
            word_q    <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            beatCnt_q <= beatCnt_d;
            cancel_q  <= cancel_d;
            kill_q    <= kill_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
        end
    end

    // Tags are only meaningful behind a set valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (tagWe) begin
            tag_q[fillIdx] <= fillTag;
        end
    end

    assign bus.ifu_req_ready  = ready;
    assign bus.ifu_resp_valid = (state_q == RESP) && !cancel_q && !kill_q
                                && !bus.ifu_kill && !bus.flush;
    assign bus.ifu_resp_data  = word_q;
    assign bus.mem_req        = (state_q == MREQ);
    assign bus.mem_addr       = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bus.mem_len        = 8'(LINE_WORDS - 1);
    assign bus.mem_flush      = 1'b0;

`ifdef SIMULATION
    logic [63:0] hitCount_q, missCount_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCount_q  <= '0;
            missCount_q <= '0;
        end else if (accept) begin
            if (hit) hitCount_q  <= hitCount_q + 64'd1;
            else     missCount_q <= missCount_q + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized fetches
// checked against a set/tag reference model and an address-derived memory image.
module tb_icache_dm;

    localparam int LW = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bit          mValid [16];
    logic [23:0] mTag   [16];

    icache_dm_if bus ();

    icache_dm #(
        .LINE_WORDS(LW),
        .NUM_SETS  (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Backing memory image; line 0x3000_0000 holds 0x11,0x22,0x33,0x44.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:4] == 28'h3000000) return 32'h11 * ({30'd0, w[3:2]} + 32'd1);
        return {w[15:0], w[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        return mValid[a[7:4]] && (mTag[a[7:4]] == a[31:8]);
    endfunction

    task automatic modelInstall(input logic [31:0] a);
        mValid[a[7:4]] = 1'b1;
        mTag[a[7:4]]   = a[31:8];
    endtask

    task automatic modelClear();
        for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    endtask

    task automatic idleInputs();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_kill      = 1'b0;
        bus.flush         = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rlast     = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    // Issue one fetch, answer any refill from the memory image, and record what
    // the cache did over a fixed window. abortBeat leaves the refill mid-burst.
    task automatic applyStimulus(input logic [31:0] addr, input bit killAtIssue,
                                 input int flushBeat, input int killBeat, input int abortBeat,
                                 output int reqCount, output logic [31:0] reqAddr,
                                 output logic [7:0] reqLen, output int respCount,
                                 output logic [31:0] respData, output int respCycle,
                                 output bit readyAtIssue);
        bit serving;
        int beat;
        reqCount  = 0;
        respCount = 0;
        reqAddr   = '0;
        reqLen    = '0;
        respData  = '0;
        respCycle = -1;
        serving   = 1'b0;
        beat      = 0;
        @(negedge clk);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = addr;
        bus.ifu_kill      = killAtIssue;
        #1 readyAtIssue = bus.ifu_req_ready;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            idleInputs();
            #1;
            if (bus.mem_req) begin
                reqCount++;
                reqAddr = bus.mem_addr;
                reqLen  = bus.mem_len;
            end
            if (bus.ifu_resp_valid) begin
                respCount++;
                respData = bus.ifu_resp_data;
                if (respCycle < 0) respCycle = c;
            end
            if (serving && beat < LW) begin
                if (beat == abortBeat) return;
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = memWord(reqAddr + 32'(4 * beat));
                bus.mem_rlast  = (beat == LW - 1);
                bus.flush      = (beat == flushBeat);
                bus.ifu_kill   = (beat == killBeat);
                beat++;
            end
            if (bus.mem_req) serving = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idleInputs();
        bus.ifu_req_addr = '0;
        modelClear();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.ifu_req_ready); end
        checks++; if (bus.ifu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", bus.ifu_resp_valid); end
        checks++; if (bus.ifu_resp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_resp_data: got %h expected 0", bus.ifu_resp_data); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_len !== 8'd3) begin errors++; $display("[TB] FAIL reset_mem_len: got %0d expected 3", bus.mem_len); end
        checks++; if (bus.mem_flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_flush: got %b expected 0", bus.mem_flush); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %b expected 1", bus.ifu_req_ready); end
    endtask

    task automatic test_cold_fetch();
        int req, resp, cyc; logic [31:0] ra, rd; logic [7:0] rl; bit rdy;
        applyStimulus(32'h3000_0004, 0, -1, -1, -1, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL cold_ready: got %b expected 1", rdy); end
        checks++; if (req != 1) begin errors++; $display("[TB] FAIL cold_req_count: got %0d expected 1", req); end
        checks++; if (ra !== 32'h3000_0000) begin errors++; $display("[TB] FAIL cold_mem_addr: got %h expected 30000000", ra); end
        checks++; if (rl !== 8'd3) begin errors++; $display("[TB] FAIL cold_mem_len: got %0d expected 3", rl); end
        checks++; if (resp != 1) begin errors++; $display("[TB] FAIL cold_resp_count: got %0d expected 1", resp); end
        checks++; if (rd !== 32'h22) begin errors++; $display("[TB] FAIL cold_resp_data: got %h expected 00000022", rd); end
        checks++; if (cyc != LW + 1) begin errors++; $display("[TB] FAIL cold_latency: got %0d expected %0d", cyc, LW + 1); end
        modelInstall(32'h3000_0004);
        applyStimulus(32'h3000_000C, 0, -1, -1, -1, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (req != 0) begin errors++; $display("[TB] FAIL hit_req_count: got %0d expected 0", req); end
        checks++; if (resp != 1) begin errors++; $display("[TB] FAIL hit_resp_count: got %0d expected 1", resp); end
        checks++; if (rd !== 32'h44) begin errors++; $display("[TB] FAIL hit_resp_data: got %h expected 00000044", rd); end
        checks++; if (cyc != 0) begin errors++; $display("[TB] FAIL hit_latency: got %0d expected 0", cyc); end
    endtask

    task automatic test_conflict();
        int req, resp, cyc; logic [31:0] ra, rd; logic [7:0] rl; bit rdy;
        applyStimulus(32'h3000_0104, 0, -1, -1, -1, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (req != 1) begin errors++; $display("[TB] FAIL conflict_req_count: got %0d expected 1", req); end
        checks++; if (ra !== 32'h3000_0100) begin errors++; $display("[TB] FAIL conflict_mem_addr: got %h expected 30000100", ra); end
        checks++; if (rd !== memWord(32'h3000_0104)) begin errors++; $display("[TB] FAIL conflict_resp_data: got %h expected %h", rd, memWord(32'h3000_0104)); end
        modelInstall(32'h3000_0104);
        applyStimulus(32'h3000_0004, 0, -1, -1, -1, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (req != 1) begin errors++; $display("[TB] FAIL evicted_req_count: got %0d expected 1", req); end
        checks++; if (rd !== 32'h22) begin errors++; $display("[TB] FAIL evicted_resp_data: got %h expected 00000022", rd); end
        modelInstall(32'h3000_0004);
    endtask

    task automatic test_flush_refill();
        int req, resp, cyc; logic [31:0] ra, rd; logic [7:0] rl; bit rdy;
        applyStimulus(32'h4000_0028, 0, 2, -1, -1, req, ra, rl, resp, rd, cyc, rdy);
        modelClear();
        checks++; if (req != 1) begin errors++; $display("[TB] FAIL flushrefill_req_count: got %0d expected 1", req); end
        checks++; if (resp != 0) begin errors++; $display("[TB] FAIL flushrefill_resp_count: got %0d expected 0", resp); end
        applyStimulus(32'h4000_0028, 0, -1, -1, -1, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (req != 1) begin errors++; $display("[TB] FAIL flushrefetch_req_count: got %0d expected 1", req); end
        checks++; if (rd !== memWord(32'h4000_0028)) begin errors++; $display("[TB] FAIL flushrefetch_resp_data: got %h expected %h", rd, memWord(32'h4000_0028)); end
        modelInstall(32'h4000_0028);
    endtask

    task automatic test_kill_refill();
        int req, resp, cyc; logic [31:0] ra, rd; logic [7:0] rl; bit rdy;
        applyStimulus(32'h5000_0044, 0, -1, 1, -1, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (req != 1) begin errors++; $display("[TB] FAIL killrefill_req_count: got %0d expected 1", req); end
        checks++; if (resp != 0) begin errors++; $display("[TB] FAIL killrefill_resp_count: got %0d expected 0", resp); end
        modelInstall(32'h5000_0044);
        applyStimulus(32'h5000_0048, 0, -1, -1, -1, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (req != 0) begin errors++; $display("[TB] FAIL killhit_req_count: got %0d expected 0", req); end
        checks++; if (rd !== memWord(32'h5000_0048)) begin errors++; $display("[TB] FAIL killhit_resp_data: got %h expected %h", rd, memWord(32'h5000_0048)); end
        applyStimulus(32'h5000_004C, 1, -1, -1, -1, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (resp != 0) begin errors++; $display("[TB] FAIL killaccept_resp_count: got %0d expected 0", resp); end
    endtask

    task automatic test_flush_idle();
        int req, resp, cyc; logic [31:0] ra, rd; logic [7:0] rl; bit rdy;
        @(negedge clk);
        bus.flush         = 1'b1;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h5000_0044;
        #1;
        checks++; if (bus.ifu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flushidle_ready: got %b expected 0", bus.ifu_req_ready); end
        @(negedge clk);
        idleInputs();
        modelClear();
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.ifu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flushidle_not_accepted: got req=%b resp=%b expected 0 0", bus.mem_req, bus.ifu_resp_valid); end
        applyStimulus(32'h5000_0044, 0, -1, -1, -1, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (req != 1) begin errors++; $display("[TB] FAIL flushidle_refetch_req: got %0d expected 1", req); end
        checks++; if (rd !== memWord(32'h5000_0044)) begin errors++; $display("[TB] FAIL flushidle_refetch_data: got %h expected %h", rd, memWord(32'h5000_0044)); end
        modelInstall(32'h5000_0044);
    endtask

    task automatic test_reset_mid_refill();
        int req, resp, cyc; logic [31:0] ra, rd; logic [7:0] rl; bit rdy;
        applyStimulus(32'h6000_0010, 0, -1, -1, -1, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (resp != 1) begin errors++; $display("[TB] FAIL prereset_resp_count: got %0d expected 1", resp); end
        applyStimulus(32'h7000_0000, 0, -1, -1, 2, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (req != 1) begin errors++; $display("[TB] FAIL midreset_req_count: got %0d expected 1", req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.ifu_req_ready !== 1'b1 || bus.ifu_resp_valid !== 1'b0 || bus.ifu_resp_data !== 32'h0) begin errors++; $display("[TB] FAIL midreset_ifu_outputs: got ready=%b resp=%b data=%h expected 1 0 0", bus.ifu_req_ready, bus.ifu_resp_valid, bus.ifu_resp_data); end
        checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL midreset_mem_outputs: got req=%b addr=%h expected 0 0", bus.mem_req, bus.mem_addr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelClear();
        #1;
        checks++; if (bus.ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_release_ready: got %b expected 1", bus.ifu_req_ready); end
        applyStimulus(32'h6000_0010, 0, -1, -1, -1, req, ra, rl, resp, rd, cyc, rdy);
        checks++; if (req != 1) begin errors++; $display("[TB] FAIL postreset_req_count: got %0d expected 1", req); end
        checks++; if (rd !== memWord(32'h6000_0010)) begin errors++; $display("[TB] FAIL postreset_resp_data: got %h expected %h", rd, memWord(32'h6000_0010)); end
        modelInstall(32'h6000_0010);
    endtask

    task automatic test_back_to_back();
        int req, resp, cyc; logic [31:0] ra, rd; logic [7:0] unusedLen; bit rdy;
        logic [31:0] addr;
        bit kill, hit;
        int flushBeat, killBeat, expReq, expResp;
        for (int n = 0; n < 80; n++) begin
            addr = {24'h800000 + 24'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            kill      = ($urandom_range(0, 7) == 0);
            flushBeat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            killBeat  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            hit       = modelHit(addr);
            expReq    = hit ? 0 : 1;
            if (kill) expResp = 0;
            else if (hit) expResp = 1;
            else expResp = (flushBeat >= 0 || killBeat >= 0) ? 0 : 1;
            applyStimulus(addr, kill, flushBeat, killBeat, -1, req, ra, unusedLen, resp, rd, cyc, rdy);
            checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL rand_ready[%0d]: got %b expected 1", n, rdy); end
            checks++; if (req != expReq) begin errors++; $display("[TB] FAIL rand_req_count[%0d] addr=%h: got %0d expected %0d", n, addr, req, expReq); end
            checks++; if (resp != expResp) begin errors++; $display("[TB] FAIL rand_resp_count[%0d] addr=%h: got %0d expected %0d", n, addr, resp, expResp); end
            if (expResp == 1) begin
                checks++; if (rd !== memWord(addr)) begin errors++; $display("[TB] FAIL rand_resp_data[%0d] addr=%h: got %h expected %h", n, addr, rd, memWord(addr)); end
            end
            if (!hit) begin
                checks++; if (ra !== {addr[31:4], 4'h0}) begin errors++; $display("[TB] FAIL rand_mem_addr[%0d]: got %h expected %h", n, ra, {addr[31:4], 4'h0}); end
                if (flushBeat >= 0) modelClear();
                else modelInstall(addr);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] starting icache_dm bench");
        test_reset();
        test_cold_fetch();
        test_conflict();
        test_flush_refill();
        test_kill_refill();
        test_flush_idle();
        test_reset_mid_refill();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
